// File: rtl/change_dispenser.sv
// Change dispenser: pays a refund greedily as 10-cent then 2-cent coins through
// a drop/ack hopper handshake, tracking inventory and flagging ack timeouts.
module change_dispenser #(
  parameter int AMT_W   = 8,
  parameter int INV_W   = 6,
  parameter int TIMEOUT = 16,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refund_req,
  input  logic [AMT_W-1:0] refund_amt,
  input  logic             inv_load,
  input  logic [INV_W-1:0] inv_ten,
  input  logic [INV_W-1:0] inv_two,
  input  logic             coin_ack,
  input  logic             fault_clr,
  output logic             coin_drop,
  output logic             coin_val,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] change_left,
  output logic             fault,
  output logic [INV_W-1:0] ten_cnt,
  output logic [INV_W-1:0] two_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_DROP, S_GAP, S_DONE, S_FAULT
  } state_t;

  state_t           state, state_nxt;
  logic [AMT_W-1:0] rem;
  logic [TW-1:0]    tmo_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             coin_val_r;
  logic             take_ten, take_two;

  assign take_ten = (rem >= AMT_W'(10)) && (ten_cnt != '0);
  assign take_two = (rem >= AMT_W'(2))  && (two_cnt != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (refund_req) state_nxt = S_SELECT;
      S_SELECT: state_nxt = (take_ten || take_two) ? S_DROP : S_DONE;
      // ack has priority over an expiring timeout
      S_DROP: begin
        if (coin_ack)                 state_nxt = S_GAP;
        else if (tmo_cnt == TMO_LAST) state_nxt = S_FAULT;
      end
      S_GAP:    if (gap_cnt == GAP_LAST) state_nxt = S_SELECT;
      S_DONE:   state_nxt = S_IDLE;
      S_FAULT:  if (fault_clr) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    coin_drop = (state == S_DROP);
    coin_val  = coin_val_r;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    fault     = (state == S_FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem         <= '0;
      ten_cnt     <= '0;
      two_cnt     <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      coin_val_r  <= 1'b0;
      change_left <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (inv_load) begin
            ten_cnt <= inv_ten;
            two_cnt <= inv_two;
          end
          if (refund_req) rem <= refund_amt;
        end
        S_SELECT: begin
          coin_val_r <= take_ten;
          tmo_cnt    <= '0;
        end
        S_DROP: begin
          if (coin_ack) begin
            gap_cnt <= '0;
            if (coin_val_r) begin
              rem     <= rem - AMT_W'(10);
              ten_cnt <= ten_cnt - 1'b1;
            end else begin
              rem     <= rem - AMT_W'(2);
              two_cnt <= two_cnt - 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_GAP:   gap_cnt <= gap_cnt + 1'b1;
        S_DONE:  change_left <= rem;
        S_FAULT: if (fault_clr) change_left <= rem;
        default: ;
      endcase
    end
  end

endmodule
